// File: rtl/iob_merge.sv
// iob_merge: N-to-1 native-bus merger with round-robin arbitration.
// Several native-bus masters share one slave. A master is granted in IDLE,
// its request is forwarded live to the slave while in GRANT, and the grant is
// released when the slave pulses ready.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   m_req   master requests, master k at [k*REQ_W +: REQ_W],
//           each packed {valid, address, wdata, wstrb}
//   m_resp  master responses, master k at [k*RESP_W +: RESP_W],
//           each packed {rdata, ready}
//   s_req   request to the shared slave
//   s_resp  response from the shared slave
//   busy    transaction in flight (GRANT state)
module iob_merge #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int unsigned RESP_W   = DATA_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp,
  output logic                          busy
);

  localparam int unsigned GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state, state_next;
  logic [GW-1:0]   grant, grant_next;
  logic [GW-1:0]   last, last_next;
  logic [GW-1:0]   sel;
  logic [GW-1:0]   cand;
  logic            any_valid;
  logic [N_MASTERS-1:0] valid;

  // Valid bit is the MSB of each master's request slice.
  always_comb begin
    valid = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      valid[k] = m_req[k*REQ_W + REQ_W - 1];
    end
  end

  // Round-robin pick: scan last+1, last+2, ... (mod N_MASTERS) and take the
  // first requester. Scanning up to last+N_MASTERS lets the previous winner be
  // chosen again when it is the only one requesting.
  always_comb begin
    sel       = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int unsigned i = 1; i <= N_MASTERS; i++) begin
      cand = GW'((32'(last) + i) % N_MASTERS);
      if (!any_valid && valid[cand]) begin
        sel       = cand;
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(N_MASTERS - 1);
    end else begin
      state <= state_next;
      grant <= grant_next;
      last  <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last;
    s_req      = '0;
    m_resp     = '0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        // Slave ready seen here is spurious and deliberately ignored.
        if (any_valid) begin
          state_next = GRANT;
          grant_next = sel;
          last_next  = sel;
        end
      end
      GRANT: begin
        busy = 1'b1;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
          if (GW'(k) == grant) begin
            s_req                      = m_req[k*REQ_W +: REQ_W];
            m_resp[k*RESP_W +: RESP_W] = s_resp;
          end
        end
        if (s_resp[0]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
